// File: rtl/regfile_wb_sched_if.sv
// Bus between the E/M write-back sources, the decode-stage hazard check and the
// register-file write port of regfile_wb_sched.
interface regfile_wb_sched_if #(
  parameter int AW = 4,
  parameter int DW = 32
);
  logic          flush;
  logic          e_valid;
  logic [AW-1:0] e_dst;
  logic [DW-1:0] e_data;
  logic          e_ready;
  logic          m_valid;
  logic [AW-1:0] m_dst;
  logic [DW-1:0] m_data;
  logic          m_ready;
  logic          wr_en;
  logic [AW-1:0] wr_dst;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] rA;
  logic [AW-1:0] rB;
  logic          stall;
  logic          err_drop;

  modport master (
    output flush, e_valid, e_dst, e_data, m_valid, m_dst, m_data, rA, rB,
    input  e_ready, m_ready, wr_en, wr_dst, wr_data, stall, err_drop
  );

  modport slave (
    input  flush, e_valid, e_dst, e_data, m_valid, m_dst, m_data, rA, rB,
    output e_ready, m_ready, wr_en, wr_dst, wr_data, stall, err_drop
  );
endinterface

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler: one hold slot per source (E, M), one registered register-file
// write per cycle, M-first ordering on same-register conflicts, decode hazard flag.
//
// rr state | meaning
// PREF_M   | on a different-dst conflict, M is granted
// PREF_E   | on a different-dst conflict, E is granted
module regfile_wb_sched #(
  parameter int NREG = 8,
  parameter int AW   = 4,
  parameter int DW   = 32
) (
  input logic               clock,
  input logic               reset,
  regfile_wb_sched_if.slave bus
);
  typedef enum logic {PREF_M = 1'b0, PREF_E = 1'b1} pref_t;

  localparam logic [AW:0] NREG_W = (AW+1)'(NREG);

  pref_t         rr, rrNext;
  logic          hEVld, hEVldNext, hMVld, hMVldNext;
  logic [AW-1:0] hEDst, hEDstNext, hMDst, hMDstNext;
  logic [DW-1:0] hEData, hEDataNext, hMData, hMDataNext;
  logic          wrEn, wrEnNext, errDrop, errDropNext;
  logic [AW-1:0] wrDst, wrDstNext;
  logic [DW-1:0] wrData, wrDataNext;
  logic          grantE, grantM, eReady, mReady, eXfer, mXfer, eOk, mOk;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr      <= PREF_M;
      hEVld   <= 1'b0;
      hEDst   <= '0;
      hEData  <= '0;
      hMVld   <= 1'b0;
      hMDst   <= '0;
      hMData  <= '0;
      wrEn    <= 1'b0;
      wrDst   <= '0;
      wrData  <= '0;
      errDrop <= 1'b0;
    end else begin
      rr      <= rrNext;
      hEVld   <= hEVldNext;
      hEDst   <= hEDstNext;
      hEData  <= hEDataNext;
      hMVld   <= hMVldNext;
      hMDst   <= hMDstNext;
      hMData  <= hMDataNext;
      wrEn    <= wrEnNext;
      wrDst   <= wrDstNext;
      wrData  <= wrDataNext;
      errDrop <= errDropNext;
    end
  end

  always_comb begin
    // M is the older instruction, so it wins any same-register conflict
    grantM = hMVld & (~hEVld | (hEDst == hMDst) | (rr == PREF_M));
    grantE = hEVld & ~grantM;

    eReady = ~bus.flush & (~hEVld | grantE);
    mReady = ~bus.flush & (~hMVld | grantM);
    eXfer  = bus.e_valid & eReady;
    mXfer  = bus.m_valid & mReady;
    eOk    = {1'b0, bus.e_dst} < NREG_W;
    mOk    = {1'b0, bus.m_dst} < NREG_W;

    rrNext      = rr;
    hEVldNext   = hEVld & ~grantE;
    hEDstNext   = hEDst;
    hEDataNext  = hEData;
    hMVldNext   = hMVld & ~grantM;
    hMDstNext   = hMDst;
    hMDataNext  = hMData;
    wrEnNext    = grantE | grantM;
    wrDstNext   = wrDst;
    wrDataNext  = wrData;
    errDropNext = errDrop | (eXfer & ~eOk) | (mXfer & ~mOk);

    if (grantM) begin
      wrDstNext  = hMDst;
      wrDataNext = hMData;
      rrNext     = PREF_E;
    end else if (grantE) begin
      wrDstNext  = hEDst;
      wrDataNext = hEData;
      rrNext     = PREF_M;
    end

    if (eXfer & eOk) begin
      hEVldNext  = 1'b1;
      hEDstNext  = bus.e_dst;
      hEDataNext = bus.e_data;
    end
    if (mXfer & mOk) begin
      hMVldNext  = 1'b1;
      hMDstNext  = bus.m_dst;
      hMDataNext = bus.m_data;
    end

    // flush squashes the pending grant too; write address/data simply hold
    if (bus.flush) begin
      hEVldNext  = 1'b0;
      hMVldNext  = 1'b0;
      wrEnNext   = 1'b0;
      wrDstNext  = wrDst;
      wrDataNext = wrData;
      rrNext     = rr;
    end
  end

  assign bus.e_ready  = eReady;
  assign bus.m_ready  = mReady;
  assign bus.wr_en    = wrEn;
  assign bus.wr_dst   = wrDst;
  assign bus.wr_data  = wrData;
  assign bus.err_drop = errDrop;
  assign bus.stall    = (hEVld & ((hEDst == bus.rA) | (hEDst == bus.rB))) |
                        (hMVld & ((hMDst == bus.rA) | (hMDst == bus.rB)));
endmodule

// File: tb/tb_regfile_wb_sched.sv
// Randomized and directed bench for regfile_wb_sched against a slot-level model of the
// scheduling rules, plus hand-computed expectations for the named scenarios.
module tb_regfile_wb_sched;
  logic clock = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  regfile_wb_sched_if bus();

  regfile_wb_sched dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // model: index 0 = E slot, 1 = M slot
  bit          mVld [2];
  logic [3:0]  mDst [2];
  logic [31:0] mData[2];
  bit          mRr;
  bit          mWrEn;
  logic [3:0]  mWrDst;
  logic [31:0] mWrData;
  bit          mErr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int mdlGrant();
    if (mVld[0] && mVld[1]) return (mDst[0] == mDst[1] || !mRr) ? 1 : 0;
    if (mVld[1]) return 1;
    if (mVld[0]) return 0;
    return -1;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin mVld[i] = 0; mDst[i] = '0; mData[i] = '0; end
      mRr = 0; mWrEn = 0; mWrDst = '0; mWrData = '0; mErr = 0;
    end else begin
      int   g;
      bit   v  [2];
      logic [3:0]  d [2];
      logic [31:0] dt[2];
      g = mdlGrant();
      v[0] = bus.e_valid; d[0] = bus.e_dst; dt[0] = bus.e_data;
      v[1] = bus.m_valid; d[1] = bus.m_dst; dt[1] = bus.m_data;
      if (bus.flush) begin
        mVld[0] = 0; mVld[1] = 0; mWrEn = 0;
      end else begin
        if (g >= 0) begin
          mWrEn = 1; mWrDst = mDst[g]; mWrData = mData[g]; mVld[g] = 0; mRr = (g == 1);
        end else mWrEn = 0;
        for (int x = 0; x < 2; x++)
          if (v[x] && !mVld[x]) begin
            if (d[x] < 8) begin mVld[x] = 1; mDst[x] = d[x]; mData[x] = dt[x]; end
            else mErr = 1;
          end
      end
    end
  end

  int cg;
  bit cStall;
  always @(negedge clock) begin
    #2;
    if (!reset) begin
      cg = mdlGrant();
      cStall = 0;
      for (int x = 0; x < 2; x++)
        if (mVld[x] && (mDst[x] == bus.rA || mDst[x] == bus.rB)) cStall = 1;
      chk("cmp_e_ready", bus.e_ready, !bus.flush && (!mVld[0] || cg == 0));
      chk("cmp_m_ready", bus.m_ready, !bus.flush && (!mVld[1] || cg == 1));
      chk("cmp_stall", bus.stall, cStall);
      chk("cmp_wr_en", bus.wr_en, mWrEn);
      chk("cmp_err_drop", bus.err_drop, mErr);
      if (mWrEn) begin
        chk("cmp_wr_dst", bus.wr_dst, mWrDst);
        chk("cmp_wr_data", bus.wr_data, mWrData);
      end
    end
  end

  task automatic idle();
    bus.flush = 0; bus.e_valid = 0; bus.e_dst = '0; bus.e_data = '0;
    bus.m_valid = 0; bus.m_dst = '0; bus.m_data = '0; bus.rA = '0; bus.rB = '0;
  endtask

  initial begin
    int eAcc, mAcc, writes, altBad, ordBad, cyc;
    logic [3:0] lastDst;
    reset = 1;
    idle();
    repeat (3) @(negedge clock);
    reset = 0;
    @(negedge clock); #3;
    chk("rst_wr_en", bus.wr_en, 0);
    chk("rst_wr_dst", bus.wr_dst, 0);
    chk("rst_e_ready", bus.e_ready, 1);
    chk("rst_m_ready", bus.m_ready, 1);
    chk("rst_err_drop", bus.err_drop, 0);

    // single E write
    @(negedge clock);
    bus.e_valid = 1; bus.e_dst = 3; bus.e_data = 32'hABCDEF98; bus.rA = 3; bus.rB = 0;
    #3 chk("t2_e_ready", bus.e_ready, 1);
    chk("t2_stall_empty", bus.stall, 0);
    @(negedge clock); bus.e_valid = 0;
    #3 chk("t2_stall_hold", bus.stall, 1);
    chk("t2_wr_en_hold", bus.wr_en, 0);
    @(negedge clock); #3;
    chk("t2_wr_en", bus.wr_en, 1);
    chk("t2_wr_dst", bus.wr_dst, 3);
    chk("t2_wr_data", bus.wr_data, 32'hABCDEF98);
    chk("t2_stall_after", bus.stall, 0);
    @(negedge clock); #3 chk("t2_wr_en_single", bus.wr_en, 0);

    // same-dst conflict
    @(negedge clock);
    bus.e_valid = 1; bus.e_dst = 5; bus.e_data = 32'h1111_1111;
    bus.m_valid = 1; bus.m_dst = 5; bus.m_data = 32'h2222_2222; bus.rA = 5;
    @(negedge clock); bus.e_valid = 0; bus.m_valid = 0;
    #3 chk("t3_stall", bus.stall, 1);
    @(negedge clock); #3;
    chk("t3_first_en", bus.wr_en, 1);
    chk("t3_first_dst", bus.wr_dst, 5);
    chk("t3_first_data", bus.wr_data, 32'h2222_2222);
    @(negedge clock); #3;
    chk("t3_second_en", bus.wr_en, 1);
    chk("t3_second_dst", bus.wr_dst, 5);
    chk("t3_second_data", bus.wr_data, 32'h1111_1111);
    @(negedge clock); idle();

    // round-robin with both sources busy, 100 requests
    eAcc = 0; mAcc = 0; writes = 0; altBad = 0; ordBad = 0; lastDst = 4'hF;
    for (cyc = 0; cyc < 400; cyc++) begin
      @(negedge clock);
      bus.e_valid = (eAcc + mAcc < 100); bus.e_dst = 1; bus.e_data = $urandom;
      bus.m_valid = (eAcc + mAcc < 100); bus.m_dst = 2; bus.m_data = $urandom;
      #3;
      if (bus.wr_en) begin
        writes++;
        if (bus.wr_dst == lastDst) ordBad++;
        if (writes == 1 && bus.wr_dst != 2) ordBad++;
        lastDst = bus.wr_dst;
      end
      if (cyc >= 1 && bus.e_valid && bus.e_ready == bus.m_ready) altBad++;
      if (bus.e_valid && bus.e_ready) eAcc++;
      if (bus.m_valid && bus.m_ready) mAcc++;
      if (eAcc + mAcc >= 100 && writes == eAcc + mAcc && !bus.e_valid) break;
    end
    chk("t4_accepted", eAcc + mAcc, 100);
    chk("t4_writes", writes, 100);
    chk("t4_e_share", eAcc, 50);
    chk("t4_ready_alt", altBad, 0);
    chk("t4_write_order", ordBad, 0);
    idle();

    // invalid destination
    @(negedge clock); bus.m_valid = 1; bus.m_dst = 9; bus.m_data = 32'hDEAD0009;
    #3 chk("t5_m_ready", bus.m_ready, 1);
    @(negedge clock); bus.m_valid = 0;
    #3 chk("t5_no_write", bus.wr_en, 0);
    chk("t5_err", bus.err_drop, 1);
    repeat (3) @(negedge clock);
    #3 chk("t5_err_sticky", bus.err_drop, 1);

    // flush with both slots full
    @(negedge clock);
    bus.e_valid = 1; bus.e_dst = 4; bus.e_data = 32'h4444_0000;
    bus.m_valid = 1; bus.m_dst = 6; bus.m_data = 32'h6666_0000;
    @(negedge clock); bus.e_valid = 0; bus.m_valid = 0; bus.flush = 1; bus.rA = 4; bus.rB = 6;
    #3 chk("t6_e_ready_flush", bus.e_ready, 0);
    chk("t6_m_ready_flush", bus.m_ready, 0);
    chk("t6_stall_full", bus.stall, 1);
    @(negedge clock); bus.flush = 0;
    #3 chk("t6_no_write", bus.wr_en, 0);
    chk("t6_stall_clear", bus.stall, 0);
    chk("t6_e_ready", bus.e_ready, 1);
    chk("t6_m_ready", bus.m_ready, 1);
    chk("t6_err_kept", bus.err_drop, 1);

    // random traffic, checked every cycle by the compare process
    repeat (3000) begin
      @(negedge clock);
      bus.e_valid = ($urandom_range(0, 3) != 0);
      bus.e_dst   = 4'($urandom_range(0, 9));
      bus.e_data  = $urandom;
      bus.m_valid = ($urandom_range(0, 3) != 0);
      bus.m_dst   = 4'($urandom_range(0, 9));
      bus.m_data  = $urandom;
      bus.rA      = 4'($urandom_range(0, 9));
      bus.rB      = 4'($urandom_range(0, 9));
      bus.flush   = ($urandom_range(0, 31) == 0);
    end

    // reset mid-stream
    @(negedge clock); idle();
    bus.e_valid = 1; bus.e_dst = 0; bus.e_data = 32'h0E0E0E0E;
    bus.m_valid = 1; bus.m_dst = 7; bus.m_data = 32'h07070707;
    repeat (4) @(negedge clock);
    #3 chk("t1_busy_wr_en", bus.wr_en, 1);
    #1 reset = 1;
    #1;
    chk("t1_wr_en", bus.wr_en, 0);
    chk("t1_e_ready", bus.e_ready, 1);
    chk("t1_m_ready", bus.m_ready, 1);
    chk("t1_err_drop", bus.err_drop, 0);
    chk("t1_wr_data", bus.wr_data, 0);
    @(negedge clock); idle(); reset = 0;
    @(negedge clock); #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
